mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the 5-stage MIPS R2000 pipeline. It consumes the EX/MEM register outputs of the execute stage: ALU result, store data, destination register, M and WB control. It performs loads and stores over a req/ack data-memory port and stalls the pipeline while an access is outstanding. It drives the MEM/WB register, which feeds write-back and the WB-side forwarding path. It also resolves branches (`pc_src`).

## Interface
- `ACK_TIMEOUT`, 16: maximum cycles `dmem_req` stays high without `dmem_ack` before the access is aborted (range 2..255).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `res` in 32: ALU result from EX/MEM; used as the memory address and as the pass-through result.
- `write_data_ex` in 32: store data from EX/MEM.
- `write_register` in 5: destination register from EX/MEM.
- `zero` in 1: ALU zero flag from EX/MEM.
- `m_MEM` in 3: [2] branch, [1] mem_read, [0] mem_write.
- `wb_MEM` in 2: [1] mem_to_reg, [0] reg_write.
- `dmem_req` out 1: access request, registered.
- `dmem_we` out 1: 1 = write, 0 = read; valid while `dmem_req` is high.
- `dmem_addr` out 32: word address `{res[31:2],2'b00}`.
- `dmem_wdata` out 32: store data.
- `dmem_rdata` in 32: read data; sampled in the cycle `dmem_ack` is high.
- `dmem_ack` in 1: single-cycle completion pulse.
- `stall` out 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `pc_src` out 1: combinational; `m_MEM[2] & zero`.
- `read_data_wb` out 32: MEM/WB loaded data.
- `alu_res_wb` out 32: MEM/WB copy of `res`.
- `write_register_wb` out 5: MEM/WB destination register.
- `wb_WB` out 2: MEM/WB WB control.
- `mem_err` out 1: sticky timeout flag.

## Operation
- Memory op: `mop = m_MEM[1] | m_MEM[0]`. If both bits are set, the access is a write.
- FSM states:
  - IDLE, with `mop` = 0: instruction passes through; `stall` = 0.
  - IDLE, with `mop` = 1: `stall` = 1; next state BUSY; `dmem_req` <= 1; `dmem_we` <= `m_MEM[0]`; addr and wdata are latched.
  - BUSY: `dmem_req` stays high and addr/we/wdata are held stable. `stall` = `!dmem_ack && !timeout`.
  - On `dmem_ack` in BUSY: capture `dmem_rdata` into `read_data_wb` (reads only); `dmem_req` <= 0; state <= IDLE.
  - Timeout: `timeout` = (wait counter == `ACK_TIMEOUT`-1) && !`dmem_ack`. The access completes as if acked, with read data 0, and `mem_err` <= 1.
- Wait counter:
  - clears on entering BUSY;
  - increments each BUSY cycle without ack;
  - width is 8 bits.
- MEM/WB register:
  - When `stall` = 0: loads `alu_res_wb`, `write_register_wb` and `wb_WB` from the inputs. `read_data_wb` loads `dmem_rdata` if acked, 0 on timeout, and holds otherwise.
  - When `stall` = 1: `wb_WB` <= 2'b00 (bubble, so there is no duplicate register write); other MEM/WB fields hold.
- `pc_src` is purely combinational from the current inputs. It is not gated by `stall`, because a branch never has `mop` set.
- `mem_err` is cleared only by reset.

## Timing
- Reset (async, immediate):
  - state = IDLE;
  - `dmem_req` = 0, `dmem_we` = 0, `dmem_addr` = 0, `dmem_wdata` = 0;
  - all MEM/WB outputs = 0;
  - wait counter = 0;
  - `mem_err` = 0.
- Reset asserted mid-access drops `dmem_req` in the same instant. The pending access is abandoned; any late `dmem_ack` after reset is ignored in IDLE.
- Non-memory latency: 1 cycle, inputs at cycle N appear on the MEM/WB outputs after edge N.
- Memory-op latency:
  - op present at cycle N: `stall` high in N;
  - `dmem_req` high from N+1;
  - ack at cycle M ≥ N+1: `stall` low in M, MEM/WB updated at edge M, upstream advances at the same edge.
  - Minimum total latency is 2 cycles.
- `dmem_ack` while IDLE is ignored.
- Back-to-back memory ops: a second op presented in the cycle after an ack starts a fresh request.
- Timeout fires in the `ACK_TIMEOUT`-th cycle of `dmem_req`: `stall` low in that cycle, `dmem_req` low in the next.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs -> all outputs 0, `stall` = 0. Assert `rst_n` low while BUSY -> `dmem_req` falls without a clock edge.
- ALU pass-through: `res` = 0x0000_0042, `write_register` = 8, `wb_MEM` = 2'b01, `m_MEM` = 0 -> next cycle `alu_res_wb` = 0x42, `write_register_wb` = 8, `wb_WB` = 01, `stall` never high.
- Load with 3-cycle ack delay: `m_MEM` = 3'b010, `res` = 0x0000_1006 -> `dmem_addr` = 0x1004, `dmem_we` = 0. `stall` high 3 cycles, with `wb_WB` = 00 during the stall. Ack with rdata 0xDEAD_BEEF -> `read_data_wb` = 0xDEADBEEF, `wb_WB` = 2'b11.
- Store, immediate ack: `m_MEM` = 3'b001, `write_data_ex` = 0xCAFE_0001 -> `dmem_we` = 1, `dmem_wdata` = 0xCAFE0001 held until ack. `stall` high exactly 1 cycle; a second store follows back-to-back correctly.
- Timeout: `ACK_TIMEOUT` = 4, load, no ack -> `dmem_req` high exactly 4 cycles, then `mem_err` = 1 (stays until reset), `read_data_wb` = 0, pipeline resumes. A late ack is ignored.
- Branch: `m_MEM` = 3'b100 with `zero` = 1 -> `pc_src` = 1 in the same cycle. With `zero` = 0 -> `pc_src` = 0. No `dmem_req` in either case.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with req/ack data-memory port, stall control,
// ack timeout, branch resolution and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] res,
  input  logic [31:0] write_data_ex,
  input  logic [4:0]  write_register,
  input  logic        zero,
  input  logic [2:0]  m_MEM,
  input  logic [1:0]  wb_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] read_data_wb,
  output logic [31:0] alu_res_wb,
  output logic [4:0]  write_register_wb,
  output logic [1:0]  wb_WB,
  output logic        mem_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rd_q, rd_d, alu_q, alu_d;
  logic [4:0]  wr_q, wr_d;
  logic [1:0]  wb_q, wb_d;
  logic        mop, ack, timeout, done;
  assign mop     = m_MEM[1] | m_MEM[0];
  assign ack     = (state_q == BUSY) && dmem_ack;
  assign timeout = (state_q == BUSY) && (cnt_q == 8'(ACK_TIMEOUT - 1)) && !dmem_ack;
  assign done    = ack | timeout;
  // Reset forces stall low so upstream is not frozen by stale inputs.
  assign stall   = rst_n && ((state_q == IDLE) ? mop : !done);
  assign pc_src  = m_MEM[2] & zero;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q | timeout;
    if (state_q == IDLE && mop) begin
      state_d = BUSY;
      cnt_d   = 8'd0;
      req_d   = 1'b1;
      we_d    = m_MEM[0];
      addr_d  = {res[31:2], 2'b00};
      wdata_d = write_data_ex;
    end
    if (state_q == BUSY) begin
      cnt_d   = cnt_q + 8'd1;
      state_d = done ? IDLE : BUSY;
      req_d   = !done;
    end
    alu_d = stall ? alu_q : res;
    wr_d  = stall ? wr_q : write_register;
    wb_d  = stall ? 2'b00 : wb_MEM;
    rd_d  = timeout ? 32'h0 : (ack && !we_q) ? dmem_rdata : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rd_q    <= 32'h0;
      alu_q   <= 32'h0;
      wr_q    <= 5'd0;
      wb_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      wr_q    <= wr_d;
      wb_q    <= wb_d;
    end
  end
  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign mem_err           = err_q;
  assign read_data_wb      = rd_q;
  assign alu_res_wb        = alu_q;
  assign write_register_wb = wr_q;
  assign wb_WB             = wb_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed stimulus with a queue scoreboard checked by a MEM/WB monitor.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] res, write_data_ex, dmem_rdata;
  logic [4:0]  write_register;
  logic        zero, dmem_ack;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        dmem_req, dmem_we, stall, pc_src, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, read_data_wb, alu_res_wb;
  logic [4:0]  write_register_wb;
  logic [1:0]  wb_WB;
  typedef struct {
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic [1:0]  wb;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic live = 1'b0;
  logic pend = 1'b0;
  mem_access_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .res(res), .write_data_ex(write_data_ex),
    .write_register(write_register), .zero(zero), .m_MEM(m_MEM), .wb_MEM(wb_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .pc_src(pc_src), .read_data_wb(read_data_wb),
    .alu_res_wb(alu_res_wb), .write_register_wb(write_register_wb),
    .wb_WB(wb_WB), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (q.size() == 0) chk("mon_queue_empty", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("alu_res_wb", alu_res_wb, e.alu);
        chk("write_register_wb", 32'(write_register_wb), 32'(e.wr));
        chk("wb_WB", 32'(wb_WB), 32'(e.wb));
        chk("read_data_wb", read_data_wb, e.rd);
      end
    end
    pend = rst_n && live && !stall;
  end
  task automatic op(input logic [31:0] r, input logic [31:0] wd, input logic [4:0] wr,
                    input logic z, input logic [2:0] m, input logic [1:0] wb, input int dly,
                    input logic [31:0] rd, input logic [31:0] erd, input logic [31:0] eaddr,
                    input int est, input int ereq, input logic epc);
    int ns, nr, c;
    q.push_back('{alu: r, rd: erd, wr: wr, wb: wb});
    res = r; write_data_ex = wd; write_register = wr; zero = z; m_MEM = m; wb_MEM = wb;
    live = 1'b1;
    ns = 0; nr = 0; c = 0;
    forever begin
      @(negedge clk);
      if (c == 0) chk("pc_src", 32'(pc_src), 32'(epc));
      else chk("bubble_wb", 32'(wb_WB), 32'd0);
      if (dmem_req) begin
        nr++;
        chk("dmem_addr", dmem_addr, eaddr);
        chk("dmem_we", 32'(dmem_we), 32'(m[0]));
        if (m[0]) chk("dmem_wdata", dmem_wdata, wd);
      end
      if (!stall) break;
      ns++;
      @(posedge clk); #1;
      c++;
      dmem_ack   = (c == dly + 1);
      dmem_rdata = dmem_ack ? rd : 32'h0;
      if (c > 40) begin
        chk("op_cycle_budget", 32'(c), 32'd40);
        break;
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0; m_MEM = 3'b000; wb_MEM = 2'b00; live = 1'b0;
    chk("stall_cycles", 32'(ns), 32'(est));
    chk("req_cycles", 32'(nr), 32'(ereq));
  endtask
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res = $urandom; write_data_ex = $urandom; write_register = 5'($urandom);
      zero = 1'($urandom); m_MEM = 3'($urandom); wb_MEM = 2'($urandom);
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      @(negedge clk);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_addr", dmem_addr | dmem_wdata | 32'(dmem_we) | 32'(mem_err), 32'd0);
      chk("rst_memwb", alu_res_wb | read_data_wb | 32'(write_register_wb) | 32'(wb_WB), 32'd0);
    end
    res = 0; write_data_ex = 0; write_register = 0; zero = 0; m_MEM = 0; wb_MEM = 0;
    dmem_ack = 0; dmem_rdata = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(32'h0000_0042, 32'h0, 5'd8, 1'b0, 3'b000, 2'b01, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    op(32'h0000_1006, 32'h0, 5'd9, 1'b0, 3'b010, 2'b11, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
       32'h0000_1004, 3, 3, 1'b0);
    op(32'h0000_0010, 32'hCAFE_0001, 5'd0, 1'b0, 3'b001, 2'b00, 0, 32'h1111_1111,
       32'hDEAD_BEEF, 32'h0000_0010, 1, 1, 1'b0);
    op(32'h0000_2003, 32'h1234_5678, 5'd0, 1'b0, 3'b001, 2'b00, 0, 32'h2222_2222,
       32'hDEAD_BEEF, 32'h0000_2000, 1, 1, 1'b0);
    op(32'h0000_0000, 32'h0, 5'd0, 1'b1, 3'b100, 2'b00, 0, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b1);
    op(32'h0000_0005, 32'h0, 5'd0, 1'b0, 3'b100, 2'b00, 0, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    chk("mem_err_clear", 32'(mem_err), 32'd0);
    op(32'h0000_4008, 32'h0, 5'd10, 1'b0, 3'b010, 2'b11, 99, 32'h0, 32'h0, 32'h0000_4008, 4, 4, 1'b0);
    chk("mem_err_set", 32'(mem_err), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    op(32'h0000_0077, 32'h0, 5'd11, 1'b0, 3'b000, 2'b01, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("mem_err_sticky", 32'(mem_err), 32'd1);
    res = 32'h0000_3000; write_register = 5'd12; m_MEM = 3'b010; wb_MEM = 2'b11;
    @(posedge clk); #1;
    m_MEM = 3'b000; wb_MEM = 2'b00;
    @(posedge clk); #2;
    chk("req_busy", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("req_async_drop", 32'(dmem_req), 32'd0);
    chk("err_async_clear", 32'(mem_err), 32'd0);
    chk("addr_async_clear", dmem_addr, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    rst_n = 1'b1;
    op(32'h0000_0099, 32'h0, 5'd13, 1'b0, 3'b000, 2'b01, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("mem_err_after_reset", 32'(mem_err), 32'd0);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
